// File: rtl/calc_exec_ctrl.sv
//
// calc_exec_ctrl -- execute sequencer for the calculator.
//
// Accepts two signed-magnitude fixed-point operands (value = mag / SCALE)
// and an op code from calc_logic, runs them through one shared iterative
// datapath (shift-add multiplier followed by a restoring divider) and
// returns a signed-magnitude result over a start/busy/done handshake.
//
// Ports:
//   clk      in   system clock
//   rst      in   asynchronous reset, active-low
//   start    in   request pulse, sampled only while idle
//   abort    in   cancel the operation in flight (CALC_EXEC_ABORT_EN only)
//   op       in   00 add, 01 sub, 10 mul, 11 div
//   a_mag    in   operand A magnitude (scaled by SCALE)
//   a_neg    in   operand A sign, 1 = negative
//   b_mag    in   operand B magnitude (scaled by SCALE)
//   b_neg    in   operand B sign, 1 = negative
//   busy     out  high while an operation is in flight
//   done     out  one-cycle pulse when res_mag/res_neg/err are valid
//   res_mag  out  result magnitude (scaled by SCALE)
//   res_neg  out  result sign, never set for a zero result
//   err      out  divide-by-zero or overflow, held with the result
//
// Configuration macro: CALC_EXEC_ABORT_EN adds the abort input. Without
// it an operation can only be cancelled by rst.
//
// Cycle plan after the accepting edge k:
//   add/sub/div-by-zero : ADDSUB (1) -> FIN (1)              done at k+2
//   mul/div             : MUL (W) -> DIV (1 load + 2W) -> FIN done at k+3W+2
// Mul computes (a*b)/SCALE, div computes (a*SCALE)/b; both use the same
// multiplier pass followed by the same divider pass.

module calc_exec_ctrl #(
    parameter int W       = 24,
    parameter int SCALE   = 1000,
    parameter int MAX_MAG = 9999999
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
`ifdef CALC_EXEC_ABORT_EN
    input  logic         abort,
`endif
    input  logic [1:0]   op,
    input  logic [W-1:0] a_mag,
    input  logic         a_neg,
    input  logic [W-1:0] b_mag,
    input  logic         b_neg,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] res_mag,
    output logic         res_neg,
    output logic         err
);

    localparam int CW = $clog2(2*W + 1);
    localparam logic [W-1:0]   SCALE_W  = W'(SCALE);
    localparam logic [2*W-1:0] MAX_WIDE = (2*W)'(MAX_MAG);
    localparam logic [CW-1:0]  MUL_LAST = CW'(W - 1);
    localparam logic [CW-1:0]  DIV_LAST = CW'(2*W);

    typedef enum logic [2:0] {
        IDLE,
        ADDSUB,
        MUL,
        DIV,
        FIN
    } state_t;

    state_t          state;
    logic [1:0]      op_r;
    logic [W-1:0]    a_r;
    logic            a_neg_r;
    logic [W-1:0]    b_r;
    logic            b_neg_r;
    logic [CW-1:0]   cnt;

    // Multiplier: acc accumulates the product, mcand shifts left and
    // mplier shifts right. In the divider acc holds the dividend bits that
    // are still to be consumed and collects the quotient from the bottom.
    logic [2*W-1:0]  acc;
    logic [2*W-1:0]  mcand;
    logic [W-1:0]    mplier;
    logic [W-1:0]    div_rem;

    // Unchecked result, qualified for overflow in FIN.
    logic [2*W-1:0]  calc_mag;
    logic            calc_neg;
    logic            calc_err;

    logic            b_neg_eff;
    logic [2*W-1:0]  a_wide;
    logic [2*W-1:0]  b_wide;
    logic [W-1:0]    div_den;
    logic [W:0]      div_tmp;
    logic [W:0]      div_diff;
    logic            div_bit;
    logic [W-1:0]    div_rem_next;

    // Operand preparation and one restoring-division step. The divisor is
    // SCALE for mul (rescale the product) and b for div.
    always_comb begin
        b_neg_eff    = b_neg_r ^ (op_r == 2'b01);
        a_wide       = {{W{1'b0}}, a_r};
        b_wide       = {{W{1'b0}}, b_r};
        div_den      = (op_r == 2'b11) ? b_r : SCALE_W;
        div_tmp      = {div_rem, acc[2*W-1]};
        div_diff     = div_tmp - {1'b0, div_den};
        div_bit      = (div_tmp >= {1'b0, div_den});
        div_rem_next = div_bit ? div_diff[W-1:0] : div_tmp[W-1:0];
    end

    // Sequencer and datapath. Outputs are registered; res_*/err only move
    // in FIN so they stay stable for the whole time busy is high.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            res_mag  <= '0;
            res_neg  <= 1'b0;
            err      <= 1'b0;
            op_r     <= 2'b00;
            a_r      <= '0;
            a_neg_r  <= 1'b0;
            b_r      <= '0;
            b_neg_r  <= 1'b0;
            cnt      <= '0;
            acc      <= '0;
            mcand    <= '0;
            mplier   <= '0;
            div_rem  <= '0;
            calc_mag <= '0;
            calc_neg <= 1'b0;
            calc_err <= 1'b0;
        end else begin
            done <= 1'b0;
`ifdef CALC_EXEC_ABORT_EN
            if (abort && (state != IDLE)) begin
                state <= IDLE;
                busy  <= 1'b0;
            end else
`endif
            begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            op_r    <= op;
                            a_r     <= a_mag;
                            a_neg_r <= a_neg;
                            b_r     <= b_mag;
                            b_neg_r <= b_neg;
                            busy    <= 1'b1;
                            cnt     <= '0;
                            acc     <= '0;
                            mcand   <= {{W{1'b0}}, a_mag};
                            mplier  <= (op == 2'b11) ? SCALE_W : b_mag;
                            // Divide by zero bypasses the iterative path and
                            // is flagged in ADDSUB, giving add/sub latency.
                            if (!op[1] || (op == 2'b11 && b_mag == '0)) begin
                                state <= ADDSUB;
                            end else begin
                                state <= MUL;
                            end
                        end
                    end

                    ADDSUB: begin
                        calc_err <= 1'b0;
                        if (op_r == 2'b11) begin
                            calc_mag <= '0;
                            calc_neg <= 1'b0;
                            calc_err <= 1'b1;
                        end else if (a_neg_r == b_neg_eff) begin
                            calc_mag <= a_wide + b_wide;
                            calc_neg <= a_neg_r;
                        end else if (a_r >= b_r) begin
                            calc_mag <= a_wide - b_wide;
                            calc_neg <= a_neg_r;
                        end else begin
                            calc_mag <= b_wide - a_wide;
                            calc_neg <= b_neg_eff;
                        end
                        state <= FIN;
                    end

                    MUL: begin
                        if (mplier[0]) begin
                            acc <= acc + mcand;
                        end
                        mcand  <= {mcand[2*W-2:0], 1'b0};
                        mplier <= {1'b0, mplier[W-1:1]};
                        if (cnt == MUL_LAST) begin
                            cnt   <= '0;
                            state <= DIV;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end

                    // First DIV cycle clears the remainder; the next 2W
                    // cycles each retire one quotient bit into acc.
                    DIV: begin
                        if (cnt == '0) begin
                            div_rem <= '0;
                            cnt     <= cnt + 1'b1;
                        end else begin
                            div_rem <= div_rem_next;
                            acc     <= {acc[2*W-2:0], div_bit};
                            if (cnt == DIV_LAST) begin
                                calc_mag <= {acc[2*W-2:0], div_bit};
                                calc_neg <= a_neg_r ^ b_neg_r;
                                calc_err <= 1'b0;
                                cnt      <= '0;
                                state    <= FIN;
                            end else begin
                                cnt <= cnt + 1'b1;
                            end
                        end
                    end

                    // Overflow covers the full 2W-bit quotient as well as
                    // the add carry; any error reports +0.
                    FIN: begin
                        if (calc_err || (calc_mag > MAX_WIDE)) begin
                            res_mag <= '0;
                            res_neg <= 1'b0;
                            err     <= 1'b1;
                        end else begin
                            res_mag <= calc_mag[W-1:0];
                            res_neg <= calc_neg && (calc_mag != '0);
                            err     <= 1'b0;
                        end
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end

                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_calc_exec_ctrl.sv
//
// tb_calc_exec_ctrl -- scoreboard bench for calc_exec_ctrl.
// Stimulus pushes hand-computed expectations; a monitor pops one per done
// pulse and compares result, sign, error flag and start-to-done latency.

module tb_calc_exec_ctrl;

    localparam int W = 24;

    typedef struct {
        string        name;
        logic [W-1:0] mag;
        logic         neg;
        logic         err;
        int           k;
        int           lat;
    } exp_t;

    logic         clk;
    logic         rst;
    logic         start;
`ifdef CALC_EXEC_ABORT_EN
    logic         abort;
`endif
    logic [1:0]   op;
    logic [W-1:0] a_mag;
    logic         a_neg;
    logic [W-1:0] b_mag;
    logic         b_neg;
    logic         busy;
    logic         done;
    logic [W-1:0] res_mag;
    logic         res_neg;
    logic         err;

    exp_t sb[$];
    int   cyc      = 0;
    int   n_checks = 0;
    int   n_pass   = 0;

    calc_exec_ctrl #(.W(W), .SCALE(1000), .MAX_MAG(9999999)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
`ifdef CALC_EXEC_ABORT_EN
        .abort   (abort),
`endif
        .op      (op),
        .a_mag   (a_mag),
        .a_neg   (a_neg),
        .b_mag   (b_mag),
        .b_neg   (b_neg),
        .busy    (busy),
        .done    (done),
        .res_mag (res_mag),
        .res_neg (res_neg),
        .err     (err)
    );

    // Free-running clock and edge counter used for latency measurement.
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act === req) begin
            n_pass++;
        end else begin
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // Called between edges; start is seen at the next posedge (edge k).
    task automatic applyStimulus(input string name, input logic [1:0] o,
                                 input logic [W-1:0] a, input logic an,
                                 input logic [W-1:0] b, input logic bn,
                                 input logic expect_done,
                                 input logic [W-1:0] em, input logic en,
                                 input logic ee, input int lat);
        exp_t e;
        op    = o;
        a_mag = a;
        a_neg = an;
        b_mag = b;
        b_neg = bn;
        start = 1'b1;
        if (expect_done) begin
            e.name = name;
            e.mag  = em;
            e.neg  = en;
            e.err  = ee;
            e.k    = cyc + 1;
            e.lat  = lat;
            sb.push_back(e);
        end
        @(negedge clk);
        start = 1'b0;
`ifdef CALC_EXEC_ABORT_EN
        abort = 1'b0;
`endif
    endtask

    task automatic waitDone(input int budget);
        int n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (sb.size() != 0) begin
            n_checks++;
            $display("[TB] FAIL timeout: %0d results still pending after %0d cycles, expected 0", sb.size(), budget);
            sb.delete();
        end
    endtask

    // Monitor: every done pulse must match the oldest pending expectation.
    always @(negedge clk) begin
        if (done) begin
            if (sb.size() == 0) begin
                n_checks++;
                $display("[TB] FAIL unexpected_done: got done=1 at cycle %0d, expected no done", cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                checkOutput({e.name, ".res_mag"}, 64'(res_mag), 64'(e.mag));
                checkOutput({e.name, ".res_neg"}, 64'(res_neg), 64'(e.neg));
                checkOutput({e.name, ".err"},     64'(err),     64'(e.err));
                checkOutput({e.name, ".latency"}, 64'(cyc - e.k), 64'(e.lat));
            end
        end
    end

    initial begin
        rst   = 1'b0;
        start = 1'b0;
`ifdef CALC_EXEC_ABORT_EN
        abort = 1'b0;
`endif
        op    = 2'b00;
        a_mag = '0;
        a_neg = 1'b0;
        b_mag = '0;
        b_neg = 1'b0;

        repeat (3) @(negedge clk);
        checkOutput("reset.busy",    64'(busy),    64'd0);
        checkOutput("reset.done",    64'(done),    64'd0);
        checkOutput("reset.res_mag", 64'(res_mag), 64'd0);
        checkOutput("reset.res_neg", 64'(res_neg), 64'd0);
        checkOutput("reset.err",     64'(err),     64'd0);
        rst = 1'b1;
        @(negedge clk);

        // Multiply / divide through the iterative path (latency 74).
        applyStimulus("mul_1.5x2",   2'b10, 24'd1500, 1'b0, 24'd2000, 1'b0, 1'b1, 24'd3000,  1'b0, 1'b0, 74);
        waitDone(100);
        applyStimulus("div_1/-3",    2'b11, 24'd1000, 1'b0, 24'd3000, 1'b1, 1'b1, 24'd333,   1'b1, 1'b0, 74);
        waitDone(100);
        applyStimulus("div_2/3",     2'b11, 24'd2000, 1'b0, 24'd3000, 1'b0, 1'b1, 24'd666,   1'b0, 1'b0, 74);
        waitDone(100);
        applyStimulus("mul_neg_neg", 2'b10, 24'd2500, 1'b1, 24'd4000, 1'b1, 1'b1, 24'd10000, 1'b0, 1'b0, 74);
        waitDone(100);
        applyStimulus("mul_trunc",   2'b10, 24'd1234, 1'b0, 24'd1001, 1'b0, 1'b1, 24'd1235,  1'b0, 1'b0, 74);
        waitDone(100);
        applyStimulus("mul_ovf",     2'b10, 24'd5000000, 1'b0, 24'd3000, 1'b0, 1'b1, 24'd0,  1'b0, 1'b1, 74);
        waitDone(100);
        applyStimulus("div_zero_a",  2'b11, 24'd0,    1'b0, 24'd5000, 1'b1, 1'b1, 24'd0,     1'b0, 1'b0, 74);
        waitDone(100);

        // Divide by zero, add/sub and their sign/overflow corners.
        applyStimulus("div_by_0",    2'b11, 24'd5000, 1'b0, 24'd0,    1'b0, 1'b1, 24'd0,     1'b0, 1'b1, 2);
        waitDone(20);
        applyStimulus("sub_neg",     2'b01, 24'd2500, 1'b0, 24'd4000, 1'b0, 1'b1, 24'd1500,  1'b1, 1'b0, 2);
        waitDone(20);
        applyStimulus("add_ovf",     2'b00, 24'd9999999, 1'b0, 24'd1, 1'b0, 1'b1, 24'd0,     1'b0, 1'b1, 2);
        waitDone(20);
        applyStimulus("sub_zero",    2'b01, 24'd7000, 1'b0, 24'd7000, 1'b0, 1'b1, 24'd0,     1'b0, 1'b0, 2);
        waitDone(20);
        applyStimulus("add_mixed",   2'b00, 24'd3000, 1'b1, 24'd1200, 1'b0, 1'b1, 24'd1800,  1'b1, 1'b0, 2);
        waitDone(20);
        applyStimulus("sub_negb",    2'b01, 24'd1000, 1'b0, 24'd2000, 1'b1, 1'b1, 24'd3000,  1'b0, 1'b0, 2);
        waitDone(20);
        applyStimulus("add_max",     2'b00, 24'd9999998, 1'b0, 24'd1, 1'b0, 1'b1, 24'd9999999, 1'b0, 1'b0, 2);
        waitDone(20);

        // Starts during a mul are dropped; a start right after done is taken.
        applyStimulus("mul_busy",    2'b10, 24'd1500, 1'b0, 24'd2000, 1'b0, 1'b1, 24'd3000,  1'b0, 1'b0, 74);
        op    = 2'b00;
        a_mag = 24'd1;
        b_mag = 24'd1;
        for (int i = 0; i < 10; i++) begin
            start = 1'b1;
            @(negedge clk);
        end
        start = 1'b0;
        checkOutput("mul_busy.busy_held", 64'(busy), 64'd1);
        waitDone(100);
        applyStimulus("add_after",   2'b00, 24'd1000, 1'b0, 24'd2000, 1'b0, 1'b1, 24'd3000,  1'b0, 1'b0, 2);
        waitDone(20);

        // Reset mid-divide: outputs clear at once and no done follows.
        applyStimulus("div_rst",     2'b11, 24'd1000, 1'b0, 24'd3000, 1'b1, 1'b0, 24'd0,     1'b0, 1'b0, 0);
        repeat (30) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        checkOutput("rst_mid.busy",    64'(busy),    64'd0);
        checkOutput("rst_mid.done",    64'(done),    64'd0);
        checkOutput("rst_mid.res_mag", 64'(res_mag), 64'd0);
        checkOutput("rst_mid.res_neg", 64'(res_neg), 64'd0);
        checkOutput("rst_mid.err",     64'(err),     64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (90) @(negedge clk);
        checkOutput("rst_after.busy",  64'(busy),    64'd0);
        applyStimulus("add_recover", 2'b00, 24'd4000, 1'b1, 24'd1000, 1'b1, 1'b1, 24'd5000,  1'b1, 1'b0, 2);
        waitDone(20);

`ifdef CALC_EXEC_ABORT_EN
        // Abort mid-divide keeps the previous result and issues no done.
        applyStimulus("abort_pre",   2'b00, 24'd1000, 1'b0, 24'd2000, 1'b0, 1'b1, 24'd3000,  1'b0, 1'b0, 2);
        waitDone(20);
        applyStimulus("div_abort",   2'b11, 24'd1000, 1'b0, 24'd3000, 1'b1, 1'b0, 24'd0,     1'b0, 1'b0, 0);
        repeat (29) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        #1;
        checkOutput("abort.busy",    64'(busy),    64'd0);
        checkOutput("abort.res_mag", 64'(res_mag), 64'd3000);
        checkOutput("abort.res_neg", 64'(res_neg), 64'd0);
        checkOutput("abort.err",     64'(err),     64'd0);
        repeat (90) @(negedge clk);
        abort = 1'b1;
        applyStimulus("start_abort", 2'b01, 24'd500,  1'b0, 24'd1500, 1'b0, 1'b1, 24'd1000,  1'b1, 1'b0, 2);
        waitDone(20);
`endif

        repeat (5) @(negedge clk);
        $display("[TB] %0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
